// File: rtl/trap_resolve.sv
// Trap resolution for the M stage: picks the winning interrupt or exception,
// routes it to M/HS/VS, and runs the WFI wait/timeout state machine.
module trap_resolve #(
   parameter int XLEN            = 64,
   parameter int S_SUPPORTED     = 1,
   parameter int H_SUPPORTED     = 1,
   parameter int WFI_TIMEOUT_BIT = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             StallW,
   input  logic             InstrValidM,
   input  logic [15:0]      ExceptionM,
   input  logic [11:0]      MIP,
   input  logic [11:0]      MIE,
   input  logic [11:0]      MIDELEG,
   input  logic [11:0]      HIDELEG,
   input  logic [15:0]      MEDELEG,
   input  logic [15:0]      HEDELEG,
   input  logic [1:0]       PrivilegeModeW,
   input  logic             VirtModeW,
   input  logic             STATUS_MIE,
   input  logic             STATUS_SIE,
   input  logic             VSSTATUS_SIE,
   input  logic             STATUS_TW,
   input  logic             wfiM,
   output logic             TrapM,
   output logic             InterruptM,
   output logic             DelegateM,
   output logic             TrapToM,
   output logic             TrapToHS,
   output logic             TrapToVS,
   output logic [XLEN-1:0]  CauseM,
   output logic             WFIStallM
);

   typedef enum logic [1:0] {IDLE, WAIT, TIMEOUT} wfi_state_t;

   localparam logic [1:0] PRIV_U = 2'b00;
   localparam logic [1:0] PRIV_S = 2'b01;
   localparam logic [1:0] PRIV_M = 2'b11;
   localparam logic       S_EN   = (S_SUPPORTED != 0);
   localparam logic       H_EN   = (H_SUPPORTED != 0);

   localparam logic [3:0] INT_ORDER [9] = '{4'd11, 4'd3, 4'd7, 4'd9, 4'd1, 4'd5, 4'd10, 4'd2, 4'd6};
   localparam logic [3:0] EXC_ORDER [15] = '{4'd3, 4'd12, 4'd1, 4'd2, 4'd0, 4'd8, 4'd9, 4'd10,
                                              4'd11, 4'd6, 4'd4, 4'd15, 4'd13, 4'd7, 4'd5};

   wfi_state_t                 state;
   logic [11:0]                PendIntW;
   logic [WFI_TIMEOUT_BIT-1:0] WfiCnt;

   logic                       priv_m, priv_s, priv_u;
   logic                       hs_en, vs_en;
   logic [11:0]                elig_m, elig_hs, elig_vs;
   logic [4:0]                 sel_m, sel_hs, sel_vs, sel_exc;
   logic                       int_taken, timeout_trap, exc_taken;
   logic                       exc_deleg, exc_to_vs;
   logic [3:0]                 int_code, exc_code, cause_code;
   logic                       cnt_full;

   // Scanning from lowest to highest priority lets the last hit win.
   function automatic logic [4:0] pick_int(input logic [11:0] v);
      pick_int = 5'd0;
      for (int k = 8; k >= 0; k--)
         if (v[INT_ORDER[k]]) pick_int = {1'b1, INT_ORDER[k]};
   endfunction

   function automatic logic [4:0] pick_exc(input logic [15:0] v);
      pick_exc = 5'd0;
      for (int k = 14; k >= 0; k--)
         if (v[EXC_ORDER[k]]) pick_exc = {1'b1, EXC_ORDER[k]};
   endfunction

   assign priv_m = (PrivilegeModeW == PRIV_M);
   assign priv_s = (PrivilegeModeW == PRIV_S);
   assign priv_u = (PrivilegeModeW == PRIV_U);

   assign hs_en   = S_EN & ~priv_m & (VirtModeW | priv_u | (priv_s & STATUS_SIE));
   assign vs_en   = S_EN & H_EN & VirtModeW & (priv_u | VSSTATUS_SIE);
   assign elig_m  = PendIntW & ~MIDELEG & {12{~priv_m | STATUS_MIE}};
   assign elig_hs = PendIntW & MIDELEG & ~HIDELEG & {12{hs_en}};
   assign elig_vs = PendIntW & MIDELEG & HIDELEG & {12{vs_en}};

   assign sel_m   = pick_int(elig_m);
   assign sel_hs  = pick_int(elig_hs);
   assign sel_vs  = pick_int(elig_vs);
   assign sel_exc = pick_exc(ExceptionM & {16{InstrValidM}});

   assign int_taken = ~reset & ~StallW & (InstrValidM | (state == WAIT))
                      & (sel_m[4] | sel_hs[4] | sel_vs[4]);
   assign int_code  = sel_m[4] ? sel_m[3:0] : (sel_hs[4] ? sel_hs[3:0] : sel_vs[3:0]);

   // A WFI timeout is reported as an illegal-instruction style exception (cause 2).
   assign timeout_trap = ~reset & (state == TIMEOUT);
   assign exc_taken    = ~reset & ~int_taken & (timeout_trap | sel_exc[4]);
   assign exc_code     = timeout_trap ? 4'd2 : sel_exc[3:0];
   assign exc_deleg    = S_EN & MEDELEG[exc_code] & ~priv_m;
   assign exc_to_vs    = exc_deleg & H_EN & HEDELEG[exc_code] & VirtModeW;

   // Output routing: interrupts go to the privilege level whose group won.
   always_comb begin
      TrapM      = 1'b0;
      InterruptM = 1'b0;
      TrapToM    = 1'b0;
      TrapToHS   = 1'b0;
      TrapToVS   = 1'b0;
      cause_code = 4'd0;
      if (int_taken) begin
         TrapM      = 1'b1;
         InterruptM = 1'b1;
         cause_code = int_code;
         TrapToM    = sel_m[4];
         TrapToHS   = ~sel_m[4] & sel_hs[4];
         TrapToVS   = ~sel_m[4] & ~sel_hs[4];
      end else if (exc_taken) begin
         TrapM      = 1'b1;
         cause_code = exc_code;
         TrapToM    = ~exc_deleg;
         TrapToHS   = exc_deleg & ~exc_to_vs;
         TrapToVS   = exc_to_vs;
      end
      DelegateM        = TrapToHS | TrapToVS;
      CauseM           = '0;
      CauseM[XLEN-1]   = InterruptM;
      CauseM[3:0]      = cause_code;
   end

   assign WFIStallM = ~reset & (state == WAIT);
   assign cnt_full  = &WfiCnt;

   // Pending-interrupt snapshot plus the WFI wait/timeout sequencer.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         PendIntW <= '0;
         state    <= IDLE;
         WfiCnt   <= '0;
      end else if (~StallW) begin
         PendIntW <= MIP & MIE;
         case (state)
            IDLE: begin
               WfiCnt <= '0;
               if (wfiM & InstrValidM & ~TrapM & ((MIP & MIE) == 12'd0))
                  state <= WAIT;
            end
            WAIT: begin
               if (PendIntW != 12'd0) begin
                  state  <= IDLE;
                  WfiCnt <= '0;
               end else if (cnt_full & STATUS_TW & ~priv_m) begin
                  state <= TIMEOUT;
               end else if (~cnt_full) begin
                  WfiCnt <= WfiCnt + {{(WFI_TIMEOUT_BIT-1){1'b0}}, 1'b1};
               end
            end
            TIMEOUT: begin
               state  <= IDLE;
               WfiCnt <= '0;
            end
            default: begin
               state  <= IDLE;
               WfiCnt <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_trap_resolve.sv
// Bench for trap_resolve: directed scenarios plus a randomized run against a
// rule-level reference model of interrupt/exception selection and routing.
module tb_trap_resolve;

   logic        clk = 1'b0;
   logic        reset;
   logic        StallW, InstrValidM, VirtModeW;
   logic [15:0] ExceptionM, MEDELEG, HEDELEG;
   logic [11:0] MIP, MIE, MIDELEG, HIDELEG;
   logic [1:0]  PrivilegeModeW;
   logic        STATUS_MIE, STATUS_SIE, VSSTATUS_SIE, STATUS_TW, wfiM;
   logic        TrapM, InterruptM, DelegateM, TrapToM, TrapToHS, TrapToVS, WFIStallM;
   logic [63:0] CauseM;

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic        trap;
      logic        intr;
      logic        deleg;
      logic        to_m;
      logic        to_hs;
      logic        to_vs;
      logic [63:0] cause;
   } exp_t;

   int int_prio [9]  = '{11, 3, 7, 9, 1, 5, 10, 2, 6};
   int exc_prio [15] = '{3, 12, 1, 2, 0, 8, 9, 10, 11, 6, 4, 15, 13, 7, 5};

   trap_resolve #(.XLEN(64), .S_SUPPORTED(1), .H_SUPPORTED(1), .WFI_TIMEOUT_BIT(4)) dut (
      .clk(clk), .reset(reset), .StallW(StallW), .InstrValidM(InstrValidM),
      .ExceptionM(ExceptionM), .MIP(MIP), .MIE(MIE), .MIDELEG(MIDELEG), .HIDELEG(HIDELEG),
      .MEDELEG(MEDELEG), .HEDELEG(HEDELEG), .PrivilegeModeW(PrivilegeModeW),
      .VirtModeW(VirtModeW), .STATUS_MIE(STATUS_MIE), .STATUS_SIE(STATUS_SIE),
      .VSSTATUS_SIE(VSSTATUS_SIE), .STATUS_TW(STATUS_TW), .wfiM(wfiM),
      .TrapM(TrapM), .InterruptM(InterruptM), .DelegateM(DelegateM), .TrapToM(TrapToM),
      .TrapToHS(TrapToHS), .TrapToVS(TrapToVS), .CauseM(CauseM), .WFIStallM(WFIStallM)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   function automatic bit can_take(int lvl, int i, logic [11:0] pend);
      bit m_mode, s_mode, u_mode;
      m_mode = (PrivilegeModeW == 2'b11);
      s_mode = (PrivilegeModeW == 2'b01);
      u_mode = (PrivilegeModeW == 2'b00);
      case (lvl)
         0: return pend[i] && !MIDELEG[i] && (!m_mode || STATUS_MIE);
         1: return pend[i] && MIDELEG[i] && !HIDELEG[i] && !m_mode &&
                   (VirtModeW || u_mode || (s_mode && STATUS_SIE));
         default: return pend[i] && MIDELEG[i] && HIDELEG[i] && VirtModeW &&
                   (u_mode || VSSTATUS_SIE);
      endcase
   endfunction

   // Expected trap outputs from the prioritisation and delegation rules.
   function automatic exp_t model_trap(input logic [11:0] pend, input bit waiting);
      exp_t e;
      bit   found, deleg;
      int   code, hit_lvl;
      e = '0;
      found = 0;
      code = 0;
      hit_lvl = 0;
      if ((InstrValidM || waiting) && !StallW)
         for (int lvl = 0; lvl < 3; lvl++)
            for (int k = 0; k < 9; k++)
               if (!found && can_take(lvl, int_prio[k], pend)) begin
                  found = 1;
                  code = int_prio[k];
                  hit_lvl = lvl;
               end
      if (found) begin
         e.trap  = 1;
         e.intr  = 1;
         e.cause = 64'h8000_0000_0000_0000 | 64'(code);
         e.to_m  = (hit_lvl == 0);
         e.to_hs = (hit_lvl == 1);
         e.to_vs = (hit_lvl == 2);
      end else if (InstrValidM) begin
         for (int k = 0; k < 15; k++)
            if (!found && ExceptionM[exc_prio[k]]) begin
               found = 1;
               code = exc_prio[k];
            end
         if (found) begin
            deleg   = MEDELEG[code] && (PrivilegeModeW != 2'b11);
            e.trap  = 1;
            e.cause = 64'(code);
            e.to_vs = deleg && HEDELEG[code] && VirtModeW;
            e.to_hs = deleg && !e.to_vs;
            e.to_m  = !deleg;
         end
      end
      e.deleg = e.to_hs || e.to_vs;
      return e;
   endfunction

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      StallW = 0; InstrValidM = 0; ExceptionM = 0; MIP = 0; MIE = 0;
      MIDELEG = 0; HIDELEG = 0; MEDELEG = 0; HEDELEG = 0;
      PrivilegeModeW = 2'b11; VirtModeW = 0;
      STATUS_MIE = 0; STATUS_SIE = 0; VSSTATUS_SIE = 0; STATUS_TW = 0; wfiM = 0;
   endtask

   task automatic flush();
      next_cycle();
      clear_inputs();
      next_cycle();
   endtask

   task automatic enter_wait(input logic [1:0] priv, input logic tw, input logic sie,
                             input logic [11:0] mideleg);
      next_cycle();
      clear_inputs();
      PrivilegeModeW = priv;
      STATUS_TW = tw;
      STATUS_SIE = sie;
      MIDELEG = mideleg;
      wfiM = 1;
      InstrValidM = 1;
      next_cycle();
      wfiM = 0;
      InstrValidM = 0;
   endtask

   task automatic test_reset();
      clear_inputs();
      reset = 1;
      InstrValidM = 1;
      ExceptionM = 16'hFFFF;
      MIP = 12'hFFF; MIE = 12'hFFF;
      repeat (2) @(posedge clk);
      @(negedge clk);
      total++;
      if ({TrapM, InterruptM, DelegateM, TrapToM, TrapToHS, TrapToVS, WFIStallM} !== 7'd0
          || CauseM !== 64'd0) begin
         bad++;
         $display("[TB] FAIL reset_outputs: got trap=%b cause=%h stall=%b, want all zero",
                  TrapM, CauseM, WFIStallM);
      end
      #2 reset = 0;
      flush();
   endtask

   task automatic test_directed();
      // Timer-style interrupt 7 in M mode, seen one cycle after MIP.
      clear_inputs();
      MIP = 12'h080; MIE = 12'h080; STATUS_MIE = 1; InstrValidM = 1;
      @(negedge clk);
      total++;
      if (TrapM !== 1'b0) begin
         bad++;
         $display("[TB] FAIL int_latency: got TrapM=%b, want 0", TrapM);
      end
      next_cycle();
      @(negedge clk);
      total++;
      if (TrapM !== 1'b1 || CauseM !== 64'h8000_0000_0000_0007 || TrapToM !== 1'b1) begin
         bad++;
         $display("[TB] FAIL int_m7: got trap=%b cause=%h toM=%b, want 1 8000000000000007 1",
                  TrapM, CauseM, TrapToM);
      end
      flush();

      // Exception 2 outranks 8, delegated to HS from U mode.
      ExceptionM = 16'h0104; PrivilegeModeW = 2'b00; MEDELEG = 16'h0004; InstrValidM = 1;
      @(negedge clk);
      total++;
      if (CauseM !== 64'd2 || TrapToHS !== 1'b1 || DelegateM !== 1'b1 || TrapM !== 1'b1) begin
         bad++;
         $display("[TB] FAIL exc_deleg_hs: got cause=%h toHS=%b deleg=%b, want 2 1 1",
                  CauseM, TrapToHS, DelegateM);
      end
      next_cycle();
      VirtModeW = 1; HEDELEG = 16'h0004;
      @(negedge clk);
      total++;
      if (TrapToVS !== 1'b1 || TrapToHS !== 1'b0 || DelegateM !== 1'b1) begin
         bad++;
         $display("[TB] FAIL exc_deleg_vs: got toVS=%b toHS=%b, want 1 0", TrapToVS, TrapToHS);
      end
      next_cycle();
      VirtModeW = 0; HEDELEG = 0; PrivilegeModeW = 2'b11;
      @(negedge clk);
      total++;
      if (TrapToM !== 1'b1 || DelegateM !== 1'b0 || CauseM !== 64'd2) begin
         bad++;
         $display("[TB] FAIL exc_m_no_deleg: got toM=%b deleg=%b cause=%h, want 1 0 2",
                  TrapToM, DelegateM, CauseM);
      end
      flush();

      // Interrupt and exception together: exception first, then interrupt 11 wins.
      MIP = 12'h808; MIE = 12'h808; STATUS_MIE = 1; ExceptionM = 16'h0004; InstrValidM = 1;
      @(negedge clk);
      total++;
      if (InterruptM !== 1'b0 || CauseM !== 64'd2) begin
         bad++;
         $display("[TB] FAIL exc_before_pend: got intr=%b cause=%h, want 0 2", InterruptM, CauseM);
      end
      next_cycle();
      @(negedge clk);
      total++;
      if (CauseM !== 64'h8000_0000_0000_000B || TrapToM !== 1'b1 || InterruptM !== 1'b1) begin
         bad++;
         $display("[TB] FAIL int_over_exc: got cause=%h toM=%b, want 800000000000000b 1",
                  CauseM, TrapToM);
      end
      flush();
   endtask

   task automatic test_random();
      exp_t        e;
      logic [11:0] model_pend;
      int          errs;
      model_pend = 12'd0;
      errs = 0;
      for (int n = 0; n < 300; n++) begin
         next_cycle();
         MIP = 12'($urandom & $urandom);
         MIE = 12'($urandom | $urandom);
         MIDELEG = 12'($urandom);
         HIDELEG = 12'($urandom);
         MEDELEG = 16'($urandom);
         HEDELEG = 16'($urandom);
         case ($urandom_range(0, 2))
            0: PrivilegeModeW = 2'b00;
            1: PrivilegeModeW = 2'b01;
            default: PrivilegeModeW = 2'b11;
         endcase
         VirtModeW = 1'($urandom);
         STATUS_MIE = 1'($urandom);
         STATUS_SIE = 1'($urandom);
         VSSTATUS_SIE = 1'($urandom);
         STATUS_TW = 1'($urandom);
         StallW = ($urandom_range(0, 7) == 0);
         InstrValidM = ($urandom_range(0, 3) != 0);
         ExceptionM = 16'($urandom & $urandom & $urandom);
         @(negedge clk);
         e = model_trap(model_pend, 1'b0);
         total++;
         if ({TrapM, InterruptM, DelegateM, TrapToM, TrapToHS, TrapToVS, CauseM} !== e
             || WFIStallM !== 1'b0) begin
            bad++;
            errs++;
            if (errs <= 10)
               $display("[TB] FAIL random[%0d]: got trap=%b int=%b dlg=%b m/hs/vs=%b%b%b cause=%h stall=%b, want trap=%b int=%b dlg=%b m/hs/vs=%b%b%b cause=%h stall=0",
                        n, TrapM, InterruptM, DelegateM, TrapToM, TrapToHS, TrapToVS, CauseM,
                        WFIStallM, e.trap, e.intr, e.deleg, e.to_m, e.to_hs, e.to_vs, e.cause);
         end
         if (!StallW) model_pend = MIP & MIE;
      end
      flush();
   endtask

   task automatic test_wfi_timeout();
      int stalls;
      enter_wait(2'b01, 1'b1, 1'b0, 12'd0);
      stalls = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (WFIStallM) stalls++;
         else break;
      end
      total++;
      if (stalls !== 16 || TrapM !== 1'b1 || CauseM !== 64'd2 || InterruptM !== 1'b0
          || TrapToM !== 1'b1) begin
         bad++;
         $display("[TB] FAIL wfi_timeout: got stalls=%0d trap=%b cause=%h, want 16 1 2",
                  stalls, TrapM, CauseM);
      end
      @(negedge clk);
      total++;
      if (TrapM !== 1'b0 || WFIStallM !== 1'b0) begin
         bad++;
         $display("[TB] FAIL wfi_timeout_once: got trap=%b stall=%b, want 0 0", TrapM, WFIStallM);
      end
      flush();
   endtask

   task automatic test_wfi_wake();
      enter_wait(2'b01, 1'b1, 1'b1, 12'h200);
      repeat (4) next_cycle();
      MIP = 12'h200; MIE = 12'h200;
      @(negedge clk);
      total++;
      if (WFIStallM !== 1'b1 || TrapM !== 1'b0) begin
         bad++;
         $display("[TB] FAIL wfi_wait_hold: got stall=%b trap=%b, want 1 0", WFIStallM, TrapM);
      end
      next_cycle();
      @(negedge clk);
      total++;
      if (InterruptM !== 1'b1 || TrapToHS !== 1'b1 || DelegateM !== 1'b1
          || CauseM !== 64'h8000_0000_0000_0009) begin
         bad++;
         $display("[TB] FAIL wfi_wake_hs: got int=%b toHS=%b cause=%h, want 1 1 8000000000000009",
                  InterruptM, TrapToHS, CauseM);
      end
      next_cycle();
      @(negedge clk);
      total++;
      if (WFIStallM !== 1'b0 || TrapM !== 1'b0) begin
         bad++;
         $display("[TB] FAIL wfi_wake_release: got stall=%b trap=%b, want 0 0", WFIStallM, TrapM);
      end
      flush();
   endtask

   task automatic test_wfi_saturate();
      int stalls;
      enter_wait(2'b01, 1'b0, 1'b0, 12'd0);
      stalls = 0;
      repeat (30) begin
         @(negedge clk);
         if (WFIStallM && !TrapM) stalls++;
      end
      total++;
      if (stalls !== 30 || dut.WfiCnt !== 4'hF) begin
         bad++;
         $display("[TB] FAIL wfi_saturate: got stalls=%0d cnt=%h, want 30 f", stalls, dut.WfiCnt);
      end
      next_cycle();
      MIP = 12'h080; MIE = 12'h080;
      next_cycle();
      STATUS_TW = 1;
      @(negedge clk);
      total++;
      if (InterruptM !== 1'b1 || CauseM !== 64'h8000_0000_0000_0007 || TrapToM !== 1'b1) begin
         bad++;
         $display("[TB] FAIL wake_vs_timeout: got int=%b cause=%h, want 1 8000000000000007",
                  InterruptM, CauseM);
      end
      next_cycle();
      @(negedge clk);
      total++;
      if (TrapM !== 1'b0 || WFIStallM !== 1'b0) begin
         bad++;
         $display("[TB] FAIL no_timeout_after_wake: got trap=%b stall=%b, want 0 0", TrapM, WFIStallM);
      end
      flush();
   endtask

   task automatic test_wfi_pending();
      MIP = 12'h080; MIE = 12'h080; PrivilegeModeW = 2'b11; STATUS_MIE = 0;
      next_cycle();
      wfiM = 1; InstrValidM = 1;
      @(negedge clk);
      total++;
      if (TrapM !== 1'b0) begin
         bad++;
         $display("[TB] FAIL wfi_masked_int: got trap=%b, want 0", TrapM);
      end
      next_cycle();
      wfiM = 0; InstrValidM = 0;
      @(negedge clk);
      total++;
      if (WFIStallM !== 1'b0) begin
         bad++;
         $display("[TB] FAIL wfi_pending_nostall: got stall=%b, want 0", WFIStallM);
      end
      flush();
   endtask

   task automatic test_reset_in_wait();
      enter_wait(2'b01, 1'b1, 1'b0, 12'd0);
      repeat (5) @(posedge clk);
      @(negedge clk);
      total++;
      if (dut.WfiCnt !== 4'd5 || WFIStallM !== 1'b1) begin
         bad++;
         $display("[TB] FAIL wait_cnt5: got cnt=%0d stall=%b, want 5 1", dut.WfiCnt, WFIStallM);
      end
      #2 reset = 1;
      InstrValidM = 1; ExceptionM = 16'h0008;
      #1;
      total++;
      if (WFIStallM !== 1'b0 || dut.WfiCnt !== 4'd0 || TrapM !== 1'b0) begin
         bad++;
         $display("[TB] FAIL reset_in_wait: got stall=%b cnt=%0d trap=%b, want 0 0 0",
                  WFIStallM, dut.WfiCnt, TrapM);
      end
      next_cycle();
      reset = 0;
      clear_inputs();
      @(negedge clk);
      total++;
      if (WFIStallM !== 1'b0 || TrapM !== 1'b0) begin
         bad++;
         $display("[TB] FAIL after_reset_idle: got stall=%b trap=%b, want 0 0", WFIStallM, TrapM);
      end
      flush();
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_wfi_timeout();
      test_wfi_wake();
      test_wfi_saturate();
      test_wfi_pending();
      test_reset_in_wait();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
